// File: rtl/tv_code_player_if.sv
// Code ROM bus between the IR code player (master) and the code table ROM (slave).
// The ROM answers combinationally: data and overflow follow the address in the same cycle.
interface tv_code_player_if #(
  parameter int unsigned ADDRESS_BITS = 13
);
  logic [ADDRESS_BITS-1:0] rom_address;
  logic [7:0]              rom_data;
  logic                    rom_overflow;

  modport master (
    output rom_address,
    input  rom_data,
    input  rom_overflow
  );

  modport slave (
    input  rom_address,
    output rom_data,
    output rom_overflow
  );
endinterface

// File: rtl/tv_code_player.sv
// Walks the IR code table in ROM record by record and drives the carrier-modulated IR LED.
// One start plays the whole table once; abort or a ROM overflow ends playback early.
module tv_code_player #(
  parameter int unsigned ADDRESS_BITS     = 13,
  parameter int unsigned TIME_UNIT_CYCLES = 120,
  parameter int unsigned GAP_UNITS        = 20000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  tv_code_player_if.master        rom,
  output logic                    ir_out,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              code_count
);

  localparam int unsigned MARK_MAX  = 255 * TIME_UNIT_CYCLES;
  localparam int unsigned GAP_LEN   = GAP_UNITS * TIME_UNIT_CYCLES;
  localparam int unsigned TIMER_MAX = (GAP_LEN > MARK_MAX) ? GAP_LEN : MARK_MAX;
  localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);

  typedef enum logic [3:0] {
    IDLE, F_CARRIER, F_COUNT, F_MARK, F_SPACE, MARK, SPACE, GAP, DONE
  } state_t;

  state_t             state;
  logic [7:0]         carrier_half;
  logic [7:0]         pairs;
  logic [7:0]         mark_units;
  logic [7:0]         space_units;
  logic [7:0]         phase;
  logic [TIMER_W-1:0] timer;

  logic [TIMER_W-1:0] mark_load;
  logic [TIMER_W-1:0] space_load;
  logic [TIMER_W-1:0] space_fetch_load;
  logic [TIMER_W-1:0] gap_load;
  logic               last_pair;
  logic               fetching;

  // Timers count down to zero, so each load is length-1.
  assign mark_load        = TIMER_W'(TIMER_W'(mark_units) * TIMER_W'(TIME_UNIT_CYCLES) - TIMER_W'(1));
  assign space_load       = TIMER_W'(TIMER_W'(space_units) * TIMER_W'(TIME_UNIT_CYCLES) - TIMER_W'(1));
  assign space_fetch_load = TIMER_W'(TIMER_W'(rom.rom_data) * TIMER_W'(TIME_UNIT_CYCLES) - TIMER_W'(1));
  assign gap_load         = TIMER_W'(GAP_LEN - 1);
  assign last_pair        = (pairs == 8'd1);
  assign fetching         = (state == F_CARRIER) || (state == F_COUNT) ||
                            (state == F_MARK) || (state == F_SPACE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rom.rom_address <= '0;
      ir_out          <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      code_count      <= 8'd0;
      carrier_half    <= 8'd0;
      pairs           <= 8'd0;
      mark_units      <= 8'd0;
      space_units     <= 8'd0;
      phase           <= 8'd0;
      timer           <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state  <= IDLE;
        ir_out <= 1'b0;
        busy   <= 1'b0;
      end else if (fetching && rom.rom_overflow) begin
        state  <= DONE;
        done   <= 1'b1;
        busy   <= 1'b0;
        ir_out <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              rom.rom_address <= '0;
              code_count      <= 8'd0;
              busy            <= 1'b1;
              state           <= F_CARRIER;
            end
          end
          F_CARRIER: begin
            carrier_half    <= rom.rom_data;
            rom.rom_address <= rom.rom_address + ADDRESS_BITS'(1);
            state           <= F_COUNT;
          end
          F_COUNT: begin
            rom.rom_address <= rom.rom_address + ADDRESS_BITS'(1);
            if (rom.rom_data == 8'd0) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              pairs <= rom.rom_data;
              state <= F_MARK;
            end
          end
          F_MARK: begin
            mark_units      <= rom.rom_data;
            rom.rom_address <= rom.rom_address + ADDRESS_BITS'(1);
            state           <= F_SPACE;
          end
          F_SPACE: begin
            space_units     <= rom.rom_data;
            rom.rom_address <= rom.rom_address + ADDRESS_BITS'(1);
            if (mark_units != 8'd0) begin
              state  <= MARK;
              timer  <= mark_load;
              ir_out <= 1'b1;
              phase  <= 8'd0;
            end else if (rom.rom_data != 8'd0) begin
              state <= SPACE;
              timer <= space_fetch_load;
            end else begin
              pairs <= pairs - 8'd1;
              timer <= gap_load;
              state <= last_pair ? GAP : F_MARK;
            end
          end
          MARK: begin
            if (timer == '0) begin
              ir_out <= 1'b0;
              if (space_units != 8'd0) begin
                state <= SPACE;
                timer <= space_load;
              end else begin
                pairs <= pairs - 8'd1;
                timer <= gap_load;
                state <= last_pair ? GAP : F_MARK;
              end
            end else begin
              timer <= timer - TIMER_W'(1);
              // carrier_half of zero leaves the LED steadily on for the mark
              if (carrier_half != 8'd0) begin
                if (phase == carrier_half - 8'd1) begin
                  ir_out <= ~ir_out;
                  phase  <= 8'd0;
                end else begin
                  phase <= phase + 8'd1;
                end
              end
            end
          end
          SPACE: begin
            if (timer == '0) begin
              pairs <= pairs - 8'd1;
              timer <= gap_load;
              state <= last_pair ? GAP : F_MARK;
            end else begin
              timer <= timer - TIMER_W'(1);
            end
          end
          GAP: begin
            if (timer == '0) begin
              code_count <= code_count + 8'd1;
              state      <= F_CARRIER;
            end else begin
              timer <= timer - TIMER_W'(1);
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tv_code_player.sv
// Directed bench for tv_code_player: small time unit and gap, ROM modelled as a byte array.
module tb_tv_code_player;
  localparam int unsigned AW = 4;
  localparam int unsigned TU = 4;
  localparam int unsigned GU = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       ir_out;
  logic       busy;
  logic       done;
  logic [7:0] code_count;

  tv_code_player_if #(.ADDRESS_BITS(AW)) bus ();

  logic [7:0] mem [16];
  int         rom_size = 0;

  assign bus.rom_overflow = (int'(bus.rom_address) >= rom_size);
  assign bus.rom_data     = bus.rom_overflow ? 8'h00 : mem[bus.rom_address];

  tv_code_player #(
    .ADDRESS_BITS    (AW),
    .TIME_UNIT_CYCLES(TU),
    .GAP_UNITS       (GU)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .rom       (bus),
    .ir_out    (ir_out),
    .busy      (busy),
    .done      (done),
    .code_count(code_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [127:0] tr_ir, tr_busy, tr_done;
  logic [3:0]   tr_addr [128];
  logic [7:0]   tr_cc   [128];
  int           done_at;
  int           n_done;

  task automatic load_rom(input logic [63:0] bytes, input int size);
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) mem[i] = bytes[63-8*i -: 8];
    rom_size = size;
  endtask

  // Start pulse on edge 0; entry k holds outputs after edge k.
  task automatic run(input logic [127:0] start_mask, input int abort_k, input int rst_k,
                     input int budget);
    tr_ir = '0; tr_busy = '0; tr_done = '0; done_at = -1; n_done = 0;
    for (int i = 0; i < 128; i++) begin tr_addr[i] = '0; tr_cc[i] = '0; end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      tr_ir[k] = ir_out; tr_busy[k] = busy; tr_done[k] = done;
      tr_addr[k] = bus.rom_address; tr_cc[k] = code_count;
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = k;
      end
      start = start_mask[k+1];
      abort = (k + 1 == abort_k);
      rst   = (k + 1 == rst_k);
      if (done_at >= 0 && k >= done_at + 2) break;
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (ir_out !== 1'b0) begin n_bad++; $display("FAIL reset_ir got %b want 0", ir_out); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (code_count !== 8'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", code_count); end
    n_vec++; if (bus.rom_address !== 4'd0) begin n_bad++; $display("FAIL reset_addr got %0d want 0", bus.rom_address); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_modulated();
    load_rom(64'h05_01_02_03_00_00_00_00, 6);
    run('0, -1, -1, 60);
    n_vec++; if (tr_ir !== 128'h1F0) begin n_bad++; $display("FAIL mod_ir_trace got %h want %h", tr_ir, 128'h1F0); end
    n_vec++; if (done_at !== 34) begin n_bad++; $display("FAIL mod_done_at got %0d want 34", done_at); end
    n_vec++; if (n_done !== 1) begin n_bad++; $display("FAIL mod_done_pulses got %0d want 1", n_done); end
    n_vec++; if (tr_busy[0] !== 1'b1) begin n_bad++; $display("FAIL mod_busy_first got %b want 1", tr_busy[0]); end
    n_vec++; if (tr_busy[33] !== 1'b1) begin n_bad++; $display("FAIL mod_busy_pre_done got %b want 1", tr_busy[33]); end
    n_vec++; if (tr_busy[34] !== 1'b0) begin n_bad++; $display("FAIL mod_busy_at_done got %b want 0", tr_busy[34]); end
    n_vec++; if (tr_cc[34] !== 8'd1) begin n_bad++; $display("FAIL mod_count got %0d want 1", tr_cc[34]); end
    n_vec++; if (tr_done[35] !== 1'b0) begin n_bad++; $display("FAIL mod_done_width got %b want 0", tr_done[35]); end
  endtask

  task automatic test_unmodulated();
    load_rom(64'h00_02_01_01_01_01_00_00, 8);
    run('0, -1, -1, 60);
    n_vec++; if (tr_ir !== 128'h3C0F0) begin n_bad++; $display("FAIL unmod_ir_trace got %h want %h", tr_ir, 128'h3C0F0); end
    n_vec++; if (done_at !== 32) begin n_bad++; $display("FAIL unmod_done_at got %0d want 32", done_at); end
    n_vec++; if (tr_cc[32] !== 8'd1) begin n_bad++; $display("FAIL unmod_count got %0d want 1", tr_cc[32]); end
  endtask

  task automatic test_mark_zero();
    load_rom(64'h00_01_00_02_00_00_00_00, 6);
    run('0, -1, -1, 60);
    n_vec++; if (tr_ir !== 128'h0) begin n_bad++; $display("FAIL mark0_ir_trace got %h want 0", tr_ir); end
    n_vec++; if (done_at !== 22) begin n_bad++; $display("FAIL mark0_done_at got %0d want 22", done_at); end
    n_vec++; if (tr_cc[22] !== 8'd1) begin n_bad++; $display("FAIL mark0_count got %0d want 1", tr_cc[22]); end
  endtask

  task automatic test_overflow();
    load_rom(64'h03_05_01_01_00_00_00_00, 4);
    run('0, -1, -1, 40);
    n_vec++; if (tr_ir !== 128'h70) begin n_bad++; $display("FAIL ovf_ir_trace got %h want %h", tr_ir, 128'h70); end
    n_vec++; if (done_at !== 13) begin n_bad++; $display("FAIL ovf_done_at got %0d want 13", done_at); end
    n_vec++; if (tr_addr[12] !== 4'd4) begin n_bad++; $display("FAIL ovf_addr got %0d want 4", tr_addr[12]); end
    n_vec++; if (tr_cc[13] !== 8'd0) begin n_bad++; $display("FAIL ovf_count got %0d want 0", tr_cc[13]); end
  endtask

  task automatic test_abort();
    load_rom(64'h05_01_02_03_00_00_00_00, 6);
    run('0, 6, -1, 12);
    n_vec++; if (tr_ir[5] !== 1'b1) begin n_bad++; $display("FAIL abort_pre_ir got %b want 1", tr_ir[5]); end
    n_vec++; if (tr_ir[6] !== 1'b0) begin n_bad++; $display("FAIL abort_ir got %b want 0", tr_ir[6]); end
    n_vec++; if (tr_busy[6] !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", tr_busy[6]); end
    n_vec++; if (n_done !== 0) begin n_bad++; $display("FAIL abort_no_done got %0d want 0", n_done); end
    run('0, -1, -1, 60);
    n_vec++; if (tr_ir !== 128'h1F0) begin n_bad++; $display("FAIL replay_ir_trace got %h want %h", tr_ir, 128'h1F0); end
    n_vec++; if (done_at !== 34) begin n_bad++; $display("FAIL replay_done_at got %0d want 34", done_at); end
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_start_idle got %b want 0", busy); end
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_start_stay got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    load_rom(64'h05_01_02_03_00_00_00_00, 6);
    run(128'h400, -1, -1, 60);
    n_vec++; if (tr_ir !== 128'h1F0) begin n_bad++; $display("FAIL b2b_ir_trace got %h want %h", tr_ir, 128'h1F0); end
    n_vec++; if (done_at !== 34) begin n_bad++; $display("FAIL b2b_done_at got %0d want 34", done_at); end
    n_vec++; if (tr_addr[10] !== 4'd4) begin n_bad++; $display("FAIL b2b_addr10 got %0d want 4", tr_addr[10]); end
    n_vec++; if (tr_addr[33] !== 4'd5) begin n_bad++; $display("FAIL b2b_addr33 got %0d want 5", tr_addr[33]); end
    run(128'h8_0000_0000, -1, -1, 60);
    n_vec++; if (done_at !== 34) begin n_bad++; $display("FAIL done_start_at got %0d want 34", done_at); end
    n_vec++; if (tr_busy[35] !== 1'b0) begin n_bad++; $display("FAIL done_start_busy35 got %b want 0", tr_busy[35]); end
    n_vec++; if (tr_busy[36] !== 1'b0) begin n_bad++; $display("FAIL done_start_busy36 got %b want 0", tr_busy[36]); end
  endtask

  task automatic test_reset_mid();
    load_rom(64'h00_01_01_00_00_01_01_00, 8);
    run('0, -1, 26, 28);
    n_vec++; if (tr_ir[20] !== 1'b1) begin n_bad++; $display("FAIL rstmid_mark2 got %b want 1", tr_ir[20]); end
    n_vec++; if (tr_cc[25] !== 8'd1) begin n_bad++; $display("FAIL rstmid_count_pre got %0d want 1", tr_cc[25]); end
    n_vec++; if (tr_busy[25] !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_pre got %b want 1", tr_busy[25]); end
    n_vec++; if (tr_busy[26] !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", tr_busy[26]); end
    n_vec++; if (tr_ir[26] !== 1'b0) begin n_bad++; $display("FAIL rstmid_ir got %b want 0", tr_ir[26]); end
    n_vec++; if (tr_done[26] !== 1'b0) begin n_bad++; $display("FAIL rstmid_done got %b want 0", tr_done[26]); end
    n_vec++; if (tr_cc[26] !== 8'd0) begin n_bad++; $display("FAIL rstmid_count got %0d want 0", tr_cc[26]); end
    n_vec++; if (tr_addr[26] !== 4'd0) begin n_bad++; $display("FAIL rstmid_addr got %0d want 0", tr_addr[26]); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    test_reset();
    test_modulated();
    test_unmodulated();
    test_mark_zero();
    test_overflow();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/tv_code_player.md
Name: tv_code_player

Overview:
- Reads the IR code table from the code ROM (combinational read: address in, data and address_overflow out in the same cycle).
- Parses the table record by record and drives the carrier-modulated IR LED output.
- Sits between the button/start logic and the IR LED driver pin; one start plays the whole table once.

Parameters:
ADDRESS_BITS, 13, ROM address width; matches the ROM's address port.
TIME_UNIT_CYCLES, 120, clocks per duration unit (10 us at 12 MHz).
GAP_UNITS, 20000, idle units inserted after each record (200 ms at default).

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to play the table; ignored while busy
abort  input  1  stop playback immediately
rom_address  output  ADDRESS_BITS  registered ROM address
rom_data  input  8  ROM data for rom_address, valid in the same cycle
rom_overflow  input  1  ROM address_overflow flag
ir_out  output  1  modulated IR drive, 1 = LED on
busy  output  1  high from the cycle after start until done or abort
done  output  1  one-cycle pulse when the table end is reached
code_count  output  8  records fully played since last start, wraps at 256

Behaviour:
- Reset: state IDLE, rom_address=0, ir_out=0, busy=0, done=0, code_count=0.
- Record format: byte0 carrier_half; byte1 pair_count N (N=0 marks the table end); then N pairs (mark_units, space_units). Records are contiguous.
- States: IDLE, F_CARRIER, F_COUNT, F_MARK, F_SPACE, MARK, SPACE, GAP, DONE.
- Each F_* state lasts exactly 1 cycle. It latches rom_data at the current rom_address, then rom_address increments by 1.
- IDLE: on start, rom_address<=0, code_count<=0, busy<=1, go to F_CARRIER.
- F_CARRIER: latch carrier_half, go to F_COUNT.
- F_COUNT:
  - If N=0, go to DONE.
  - Otherwise load the pair counter with N and go to F_MARK.
- F_MARK: latch mark, go to F_SPACE.
- F_SPACE:
  - Latch space, then go to MARK.
  - If mark=0, skip MARK and go to SPACE.
  - If both are 0, go to the next pair step.
- MARK: lasts mark*TIME_UNIT_CYCLES cycles.
  - ir_out=1 on the first cycle, then toggles every carrier_half cycles.
  - carrier_half=0 means ir_out holds 1 for the whole mark.
- SPACE: lasts space*TIME_UNIT_CYCLES cycles with ir_out=0.
- Next pair step: decrement the pair counter. If nonzero go to F_MARK, else go to GAP.
- GAP: lasts GAP_UNITS*TIME_UNIT_CYCLES cycles with ir_out=0. At the end, code_count+1 and go to F_CARRIER.
- Fetch cycles drive ir_out=0, so the low time between marks is space*TIME_UNIT_CYCLES+2 cycles.
- Unit timer is 8 bits times TIME_UNIT_CYCLES, with no overflow (max 255 units). The GAP timer is sized for GAP_UNITS*TIME_UNIT_CYCLES.
- rom_overflow=1 in any F_* state: treat as table end and go to DONE, even mid-record. code_count does not increment for a partial record.
- DONE: done=1 for 1 cycle, busy=0 and ir_out=0 in the same cycle, then IDLE next cycle.
- abort: in any non-IDLE state, the next cycle is IDLE with ir_out=0 and busy=0, no done pulse, and code_count holds.
  - abort takes priority over all transitions.
  - abort together with start in IDLE: stay IDLE.
- start while busy: ignored. start in the same cycle as the DONE pulse: ignored.
- rst mid-playback: all outputs return to reset values on the next edge.

Test Plan:
- TIME_UNIT_CYCLES=4, GAP_UNITS=2; ROM {05,01,02,03,00,00}; start -> ir_out high at the 4th cycle after start for 8 cycles with pattern 1,1,1,1,1,0,0,0, then low; code_count=1; done pulses; busy falls with done.
- ROM {00,02,01,01,01,01,00,00} -> two unmodulated 4-cycle marks separated by 6 low cycles (4 space + 2 fetch), then the GAP, then done.
- ROM pair (00,02) -> no mark; low time extended by 8 cycles; no glitch on ir_out.
- SIZE=4 with table {03,05,01,01} truncated -> overflow at F_MARK address 4 -> done pulse, code_count=0.
- abort asserted during MARK -> next cycle ir_out=0, busy=0, no done; a following start replays from address 0.
- start pulsed again while busy -> ignored; rom_address sequence unchanged; rst during GAP -> all outputs 0 next cycle.
